mdu_issue_sched: RTL and testbench

MDU_ISSUE_SCHED -- requirements
Module: mdu_issue_sched

---
 rtl/mdu_issue_sched.sv | 168 ++++++++++++++++
 tb/tb_mdu_issue_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_sched.sv
// rtl/mdu_issue_sched.sv - age-ordered compacting issue queue for the multiply/divide unit
// Oldest-ready-first select with wakeup capture and a shared-divider busy window.
module mdu_issue_sched #(
    parameter int DEPTH   = 4,
    parameter int PREG_W  = 6,
    parameter int UOP_W   = 64,
    parameter int DIV_LAT = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  pause,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [UOP_W-1:0]      enq_uop,
    input  logic [PREG_W-1:0]     enq_src0,
    input  logic [PREG_W-1:0]     enq_src1,
    input  logic                  enq_src0_rdy,
    input  logic                  enq_src1_rdy,
    input  logic                  enq_is_div,
    input  logic [1:0]            wake_valid,
    input  logic [2*PREG_W-1:0]   wake_preg,
    output logic                  iss_valid,
    output logic [UOP_W-1:0]      iss_uop,
    output logic [PREG_W-1:0]     iss_src0,
    output logic [PREG_W-1:0]     iss_src1,
    output logic                  div_busy
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BUSY_W = (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  rdy0_q, rdy0_d;
    logic [DEPTH-1:0]  rdy1_q, rdy1_d;
    logic [DEPTH-1:0]  div_q, div_d;
    logic [UOP_W-1:0]  uop_q  [DEPTH];
    logic [UOP_W-1:0]  uop_d  [DEPTH];
    logic [PREG_W-1:0] src0_q [DEPTH];
    logic [PREG_W-1:0] src0_d [DEPTH];
    logic [PREG_W-1:0] src1_q [DEPTH];
    logic [PREG_W-1:0] src1_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BUSY_W-1:0] busy_q, busy_d;

    logic              has_sel;
    logic [IDX_W-1:0]  sel_idx;
    logic [DEPTH-1:0]  woken0, woken1;
    logic [CNT_W-1:0]  count_after;
    logic              enq_fire;

    function automatic logic wake_hit(input logic [PREG_W-1:0]   tag,
                                      input logic [1:0]          wv,
                                      input logic [2*PREG_W-1:0] wp);
        return (wv[0] && (wp[0 +: PREG_W] == tag)) ||
               (wv[1] && (wp[PREG_W +: PREG_W] == tag));
    endfunction

    assign div_busy  = (busy_q != '0);
    assign enq_ready = (count_q < CNT_W'(DEPTH));
    assign iss_valid = has_sel && !pause && !div_busy && !flush;
    assign iss_uop   = iss_valid ? uop_q[sel_idx]  : '0;
    assign iss_src0  = iss_valid ? src0_q[sel_idx] : '0;
    assign iss_src1  = iss_valid ? src1_q[sel_idx] : '0;

    // Descending scan so the lowest (oldest) eligible index wins.
    always_comb begin
        has_sel = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rdy0_q[i] && rdy1_q[i]) begin
                has_sel = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken0[i] = rdy0_q[i] | (valid_q[i] & wake_hit(src0_q[i], wake_valid, wake_preg));
            woken1[i] = rdy1_q[i] | (valid_q[i] & wake_hit(src1_q[i], wake_valid, wake_preg));
        end

        valid_d = valid_q;
        rdy0_d  = woken0;
        rdy1_d  = woken1;
        div_d   = div_q;
        uop_d   = uop_q;
        src0_d  = src0_q;
        src1_d  = src1_q;

        // Compaction: entries above the issued slot slide down, carrying this cycle's wakeups.
        if (iss_valid) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    valid_d[i] = valid_q[i+1];
                    rdy0_d[i]  = woken0[i+1];
                    rdy1_d[i]  = woken1[i+1];
                    div_d[i]   = div_q[i+1];
                    uop_d[i]   = uop_q[i+1];
                    src0_d[i]  = src0_q[i+1];
                    src1_d[i]  = src1_q[i+1];
                end
            end
            valid_d[DEPTH-1] = 1'b0;
        end

        count_after = count_q - CNT_W'(iss_valid);
        enq_fire    = enq_valid && enq_ready && !flush;

        if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count_after) begin
                    valid_d[i] = 1'b1;
                    rdy0_d[i]  = enq_src0_rdy | wake_hit(enq_src0, wake_valid, wake_preg);
                    rdy1_d[i]  = enq_src1_rdy | wake_hit(enq_src1, wake_valid, wake_preg);
                    div_d[i]   = enq_is_div;
                    uop_d[i]   = enq_uop;
                    src0_d[i]  = enq_src0;
                    src1_d[i]  = enq_src1;
                end
            end
        end
        count_d = count_after + CNT_W'(enq_fire);

        if (iss_valid && div_q[sel_idx]) begin
            busy_d = BUSY_W'(DIV_LAT);
        end else if (busy_q != '0) begin
            busy_d = busy_q - 1'b1;
        end else begin
            busy_d = busy_q;
        end

        if (flush) begin
            valid_d = '0;
            count_d = '0;
            busy_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rdy0_q  <= '0;
            rdy1_q  <= '0;
            div_q   <= '0;
            count_q <= '0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                uop_q[i]  <= '0;
                src0_q[i] <= '0;
                src1_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            div_q   <= div_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            uop_q   <= uop_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
        end
    end

endmodule

// File: tb/tb_mdu_issue_sched.sv
// tb/tb_mdu_issue_sched.sv - self-checking bench for mdu_issue_sched
module tb_mdu_issue_sched;

    localparam int PW = 6;
    localparam int UW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, pause;
    logic          enq_valid, enq_ready;
    logic [UW-1:0] enq_uop;
    logic [PW-1:0] enq_src0, enq_src1;
    logic          enq_src0_rdy, enq_src1_rdy, enq_is_div;
    logic [1:0]    wake_valid;
    logic [2*PW-1:0] wake_preg;
    logic          iss_valid;
    logic [UW-1:0] iss_uop;
    logic [PW-1:0] iss_src0, iss_src1;
    logic          div_busy;

    int total = 0;
    int bad   = 0;

    mdu_issue_sched #(.DEPTH(4), .PREG_W(PW), .UOP_W(UW), .DIV_LAT(36)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pause(pause),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_uop(enq_uop),
        .enq_src0(enq_src0), .enq_src1(enq_src1),
        .enq_src0_rdy(enq_src0_rdy), .enq_src1_rdy(enq_src1_rdy), .enq_is_div(enq_is_div),
        .wake_valid(wake_valid), .wake_preg(wake_preg),
        .iss_valid(iss_valid), .iss_uop(iss_uop), .iss_src0(iss_src0), .iss_src1(iss_src1),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ev;
        logic [UW-1:0] uop;
        logic [PW-1:0] s0, s1;
        logic          r0, r1;
        logic [1:0]    wv;
        logic [2*PW-1:0] wp;
        logic          ps;
        logic          x_iv;
        logic [UW-1:0] x_uop;
        logic [PW-1:0] x_s0, x_s1;
    } vec_t;

    typedef struct {
        logic [UW-1:0] uop;
        logic [PW-1:0] s0, s1;
    } iss_t;

    vec_t tbl[15];
    iss_t exp_q[$];
    iss_t sb_e;

    function automatic vec_t mk(input logic ev, input logic [UW-1:0] uop,
                                input logic [PW-1:0] s0, s1, input logic r0, r1,
                                input logic [1:0] wv, input logic [2*PW-1:0] wp, input logic ps,
                                input logic x_iv, input logic [UW-1:0] x_uop,
                                input logic [PW-1:0] x_s0, x_s1);
        vec_t v;
        v.ev = ev; v.uop = uop; v.s0 = s0; v.s1 = s1; v.r0 = r0; v.r1 = r1;
        v.wv = wv; v.wp = wp; v.ps = ps;
        v.x_iv = x_iv; v.x_uop = x_uop; v.x_s0 = x_s0; v.x_s1 = x_s1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic idle();
        flush = 1'b0; pause = 1'b0; enq_valid = 1'b0; enq_uop = '0;
        enq_src0 = '0; enq_src1 = '0; enq_src0_rdy = 1'b0; enq_src1_rdy = 1'b0;
        enq_is_div = 1'b0; wake_valid = '0; wake_preg = '0;
    endtask

    task automatic enq(input logic [UW-1:0] u, input logic [PW-1:0] a, b,
                       input logic ra, rb, dv);
        enq_valid = 1'b1; enq_uop = u; enq_src0 = a; enq_src1 = b;
        enq_src0_rdy = ra; enq_src1_rdy = rb; enq_is_div = dv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push_exp(input logic [UW-1:0] u, input logic [PW-1:0] a, b);
        iss_t e;
        e.uop = u; e.s0 = a; e.s1 = b;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && iss_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got uop %h want no issue", iss_uop);
            end else begin
                sb_e = exp_q.pop_front();
                if (iss_uop !== sb_e.uop || iss_src0 !== sb_e.s0 || iss_src1 !== sb_e.s1) begin
                    bad++;
                    $display("FAIL sb_issue: got %h/%0d/%0d want %h/%0d/%0d",
                             iss_uop, iss_src0, iss_src1, sb_e.uop, sb_e.s0, sb_e.s1);
                end
            end
        end
    end

    initial begin
        tbl[0]  = mk(1, 64'hA1, 1, 2, 1, 1, 2'b00, 12'd0, 0, 0, 64'h0, 0, 0);
        tbl[1]  = mk(0, 64'h0, 0, 0, 0, 0, 2'b00, 12'd0, 0, 1, 64'hA1, 1, 2);
        tbl[2]  = mk(1, 64'hB2, 5, 3, 0, 1, 2'b00, 12'd0, 0, 0, 64'h0, 0, 0);
        tbl[3]  = mk(0, 64'h0, 0, 0, 0, 0, 2'b10, {6'd5, 6'd0}, 0, 0, 64'h0, 0, 0);
        tbl[4]  = mk(0, 64'h0, 0, 0, 0, 0, 2'b00, 12'd0, 0, 1, 64'hB2, 5, 3);
        tbl[5]  = mk(1, 64'hC3, 7, 8, 0, 1, 2'b00, 12'd0, 0, 0, 64'h0, 0, 0);
        tbl[6]  = mk(1, 64'hD4, 9, 10, 1, 1, 2'b00, 12'd0, 0, 0, 64'h0, 0, 0);
        tbl[7]  = mk(0, 64'h0, 0, 0, 0, 0, 2'b01, {6'd0, 6'd7}, 0, 1, 64'hD4, 9, 10);
        tbl[8]  = mk(0, 64'h0, 0, 0, 0, 0, 2'b00, 12'd0, 0, 1, 64'hC3, 7, 8);
        tbl[9]  = mk(1, 64'hE5, 11, 12, 0, 0, 2'b11, {6'd12, 6'd11}, 0, 0, 64'h0, 0, 0);
        tbl[10] = mk(0, 64'h0, 0, 0, 0, 0, 2'b00, 12'd0, 0, 1, 64'hE5, 11, 12);
        tbl[11] = mk(1, 64'hF6, 13, 14, 1, 1, 2'b00, 12'd0, 0, 0, 64'h0, 0, 0);
        tbl[12] = mk(0, 64'h0, 0, 0, 0, 0, 2'b00, 12'd0, 1, 0, 64'h0, 0, 0);
        tbl[13] = mk(0, 64'h0, 0, 0, 0, 0, 2'b00, 12'd0, 0, 1, 64'hF6, 13, 14);
        tbl[14] = mk(0, 64'h0, 0, 0, 0, 0, 2'b00, 12'd0, 0, 0, 64'h0, 0, 0);

        rst = 1'b1;
        idle();
        #2;
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_iss_uop", iss_uop, 0);
        chk("rst_div_busy", div_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: single issue, late wakeup, out-of-order issue, enqueue-time wakeup, pause.
        for (int k = 0; k < 15; k++) begin
            if (tbl[k].ev) enq(tbl[k].uop, tbl[k].s0, tbl[k].s1, tbl[k].r0, tbl[k].r1, 1'b0);
            wake_valid = tbl[k].wv;
            wake_preg  = tbl[k].wp;
            pause      = tbl[k].ps;
            #2;
            chk($sformatf("row%0d_iss_valid", k), iss_valid, tbl[k].x_iv);
            chk($sformatf("row%0d_iss_uop", k), iss_uop, tbl[k].x_uop);
            chk($sformatf("row%0d_iss_src0", k), iss_src0, tbl[k].x_s0);
            chk($sformatf("row%0d_enq_ready", k), enq_ready, 1);
            chk($sformatf("row%0d_div_busy", k), div_busy, 0);
            if (tbl[k].x_iv) push_exp(tbl[k].x_uop, tbl[k].x_s0, tbl[k].x_s1);
            step();
        end

        // Divide blocks a ready multiply for exactly DIV_LAT cycles.
        enq(64'h71, 1, 2, 1, 1, 1);
        #2;
        chk("div_pre_iss", iss_valid, 0);
        step();
        enq(64'h72, 3, 4, 1, 1, 0);
        #2;
        chk("div_iss_valid", iss_valid, 1);
        chk("div_iss_uop", iss_uop, 64'h71);
        push_exp(64'h71, 1, 2);
        step();
        for (int k = 1; k <= 36; k++) begin
            #2;
            chk($sformatf("div_busy_t%0d", k), div_busy, 1);
            chk($sformatf("div_block_t%0d", k), iss_valid, 0);
            step();
        end
        #2;
        chk("mul_after_div_valid", iss_valid, 1);
        chk("mul_after_div_uop", iss_uop, 64'h72);
        chk("mul_after_div_busy", div_busy, 0);
        push_exp(64'h72, 3, 4);
        step();
        #2;
        chk("mul_after_div_empty", iss_valid, 0);
        step();

        // Fill to full, pause, issue one, then flush mid-divide.
        enq(64'h80, 20, 21, 0, 1, 1);
        #2; chk("fill0_ready", enq_ready, 1); step();
        enq(64'h81, 22, 21, 0, 1, 0);
        #2; chk("fill1_ready", enq_ready, 1); step();
        enq(64'h82, 23, 21, 0, 1, 0);
        #2; chk("fill2_ready", enq_ready, 1); step();
        enq(64'h83, 24, 21, 0, 1, 0);
        #2; chk("fill3_ready", enq_ready, 1); step();
        enq(64'h8F, 1, 2, 1, 1, 0);
        wake_valid = 2'b01;
        wake_preg  = {6'd0, 6'd20};
        #2;
        chk("full_ready", enq_ready, 0);
        chk("full_no_iss", iss_valid, 0);
        step();
        pause = 1'b1;
        #2;
        chk("pause_iss", iss_valid, 0);
        chk("pause_full", enq_ready, 0);
        step();
        #2;
        chk("full_iss_valid", iss_valid, 1);
        chk("full_iss_uop", iss_uop, 64'h80);
        chk("full_iss_ready_held", enq_ready, 0);
        push_exp(64'h80, 20, 21);
        step();
        #2;
        chk("after_iss_ready", enq_ready, 1);
        chk("after_iss_busy", div_busy, 1);
        for (int k = 0; k < 16; k++) step();
        flush = 1'b1;
        enq(64'h90, 1, 2, 1, 1, 0);
        #2;
        chk("flush_cycle_busy", div_busy, 1);
        chk("flush_cycle_iss", iss_valid, 0);
        step();
        wake_valid = 2'b11;
        wake_preg  = {6'd23, 6'd22};
        #2;
        chk("post_flush_busy", div_busy, 0);
        chk("post_flush_ready", enq_ready, 1);
        chk("post_flush_iss", iss_valid, 0);
        step();
        #2;
        chk("post_flush_stale", iss_valid, 0);
        enq(64'hB1, 30, 31, 0, 1, 0); step();
        enq(64'hB2, 32, 31, 0, 1, 0); step();
        enq(64'hB3, 33, 31, 0, 1, 0); step();
        #2;
        chk("post_flush_count", enq_ready, 1);
        flush = 1'b1;
        step();

        // Asynchronous reset mid-divide and mid-issue.
        enq(64'hA0, 1, 2, 1, 1, 1);
        #2; chk("rstseq_pre", iss_valid, 0); step();
        enq(64'hA1, 3, 4, 1, 1, 0);
        #2;
        chk("rstseq_div_iss", iss_uop, 64'hA0);
        push_exp(64'hA0, 1, 2);
        step();
        #2;
        chk("rstseq_busy", div_busy, 1);
        rst = 1'b1;
        #1;
        chk("rstseq_busy_clr", div_busy, 0);
        chk("rstseq_ready", enq_ready, 1);
        chk("rstseq_iss", iss_valid, 0);
        step();
        rst = 1'b0;
        #2;
        chk("rstseq_released_busy", div_busy, 0);
        chk("rstseq_cleared_q", iss_valid, 0);
        step();
        enq(64'hC0, 5, 6, 1, 1, 0);
        #2; chk("rstseq_enq", iss_valid, 0); step();
        #2;
        chk("rstseq_first_iss", iss_valid, 1);
        chk("rstseq_first_uop", iss_uop, 64'hC0);
        rst = 1'b1;
        #1;
        chk("rstseq_iss_async", iss_valid, 0);
        chk("rstseq_uop_async", iss_uop, 0);
        step();
        rst = 1'b0;
        #2;
        chk("rstseq_final_iss", iss_valid, 0);
        chk("sb_drained", exp_q.size(), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
